multicycle_control: RTL

- Control FSM that sequences the MIPS-subset datapath in multi-cycle form: FETCH, DECODE, EXEC, MEM, WB.
- Uses the same instruction subset and ALU encoding as the single-cycle decoder: addu, subu, and, or, sltu, lw, sw, beq, addiu, j.
- Handles variable-latency unified memory via a req/ready handshake, traps illegal encodings and memory timeouts, and counts retired instructions.
- Sits between the instruction register (IR), the ALU/register file/PC datapath and the memory port.

---
 rtl/mc_pkg.sv | 59 +++++
 rtl/mc_mem_wait.sv | 37 +++
 rtl/multicycle_control.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control FSM.
package mc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnSltu = 6'b101011;

  localparam logic [2:0] AluAdd  = 3'b101;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluAnd  = 3'b111;
  localparam logic [2:0] AluOr   = 3'b110;
  localparam logic [2:0] AluSltu = 3'b000;

  localparam logic [1:0] PcSrcSeq    = 2'b00;
  localparam logic [1:0] PcSrcBranch = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  localparam logic [1:0] CauseNone    = 2'b00;
  localparam logic [1:0] CauseOpcode  = 2'b01;
  localparam logic [1:0] CauseFunct   = 2'b10;
  localparam logic [1:0] CauseTimeout = 2'b11;

  function automatic logic funct_legal(input logic [5:0] funct);
    return funct inside {FnAddu, FnSubu, FnAnd, FnOr, FnSltu};
  endfunction

  function automatic logic [2:0] alu_for_funct(input logic [5:0] funct);
    logic [2:0] alu;
    alu = AluAdd;
    case (funct)
      FnSubu:  alu = AluSub;
      FnAnd:   alu = AluAnd;
      FnOr:    alu = AluOr;
      FnSltu:  alu = AluSltu;
      default: alu = AluAdd;
    endcase
    return alu;
  endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// Memory wait-cycle counter; expired flags that MEM_TIMEOUT waits have elapsed.
module mc_mem_wait #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(MEM_TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;

  // A zero limit disables the timeout; the counter may then wrap harmlessly.
  assign expired = (MEM_TIMEOUT != 0) && (cnt_q == Limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/exec/mem/writeback, traps
// illegal encodings and memory timeouts, and counts retired instructions.
module multicycle_control import mc_pkg::*; #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             pcwrite,
  output logic [1:0]       pcsrc,
  output logic             alusrcbimm,
  output logic [2:0]       alucontrol,
  output logic             regwrite,
  output logic [4:0]       destreg,
  output logic             memtoreg,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             wait_clr, wait_en, wait_expired;

  logic [5:0] opcode, funct;
  logic       unused_instr;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_instr = ^{instr[25:21], instr[10:6]};

  mc_mem_wait #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (wait_clr),
    .en      (wait_en),
    .expired (wait_expired)
  );

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    retire     = 1'b0;
    wait_en    = 1'b0;
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    pcsrc      = PcSrcSeq;
    alusrcbimm = 1'b0;
    alucontrol = AluAdd;
    regwrite   = 1'b0;
    destreg    = '0;
    memtoreg   = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        mem_req = 1'b1;
        wait_en = !mem_ready;
        // Ready in the expiry cycle still completes the access.
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = StDecode;
        end else if (wait_expired) begin
          cause_d = CauseTimeout;
          state_d = StTrap;
        end
      end
      StDecode: begin
        case (opcode)
          OpJ: begin
            pcwrite = 1'b1;
            pcsrc   = PcSrcJump;
            retire  = 1'b1;
            state_d = StFetch;
          end
          OpRtype: begin
            if (funct_legal(funct)) begin
              state_d = StExec;
            end else begin
              cause_d = CauseFunct;
              state_d = StTrap;
            end
          end
          OpLw, OpSw, OpBeq, OpAddiu: state_d = StExec;
          default: begin
            cause_d = CauseOpcode;
            state_d = StTrap;
          end
        endcase
      end
      StExec: begin
        case (opcode)
          OpRtype: begin
            alucontrol = alu_for_funct(funct);
            state_d    = StWb;
          end
          OpBeq: begin
            alucontrol = AluSub;
            if (zero) begin
              pcwrite = 1'b1;
              pcsrc   = PcSrcBranch;
            end
            retire  = 1'b1;
            state_d = StFetch;
          end
          OpAddiu: begin
            alusrcbimm = 1'b1;
            state_d    = StWb;
          end
          default: begin
            alusrcbimm = 1'b1;
            state_d    = StMem;
          end
        endcase
      end
      StMem: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = (opcode == OpSw);
        wait_en  = !mem_ready;
        if (mem_ready) begin
          if (opcode == OpSw) begin
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (wait_expired) begin
          cause_d = CauseTimeout;
          state_d = StTrap;
        end
      end
      StWb: begin
        regwrite = 1'b1;
        destreg  = (opcode == OpRtype) ? instr[15:11] : instr[20:16];
        memtoreg = (opcode == OpLw);
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StTrap: state_d = StTrap;
      default: state_d = StIdle;
    endcase

    wait_clr = (state_d != state_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cause_q   <= CauseNone;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign trap       = (state_q == StTrap);
  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule
